nes_boot_controller: RTL and testbench

- Top-level boot sequencer for the NES SoC, running on nios_clk.
- Waits until the UART receive buffer holds a complete NROM cartridge image, then checks the 4-byte iNES magic.
- Reports the result over UART: "S" (0x53) for pass, "F" (0x46) for fail.
- On pass, streams the PRG+CHR payload into the cartridge ROM programming port, then releases the console to run.

---
 rtl/nes_boot_controller.sv | 144 ++++++++++++++
 tb/tb_nes_boot_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_boot_controller.sv
// nes_boot_controller
// Boot sequencer for the NES SoC. It waits until the UART receive buffer holds
// a complete NROM image, then checks the 4-byte iNES magic and reports the
// result over UART ("S" or "F"). On a pass it streams the PRG+CHR payload into
// the cartridge ROM programming port, one byte per cycle, and then releases
// the CPU/PPU. Every output comes straight from a register.
module nes_boot_controller #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] NROM_END = 16'h600F,
  parameter int              HDR_LEN  = 16
) (
  input  logic              nios_clk,
  input  logic              rst,
  input  logic              read_valid,
  input  logic [7:0]        uart_DO,
  input  logic              send_done,
  output logic [ADDR_W-1:0] read_ptr,
  output logic              rx_clear,
  output logic              tx_clear,
  output logic [15:0]       send_ptr,
  output logic [7:0]        tx_DI,
  output logic              rom_prog,
  output logic [7:0]        rom_prog_di,
  output logic [ADDR_W-1:0] rom_prog_addr,
  output logic              cpu_run,
  output logic [2:0]        nes_state
);

  localparam logic [2:0] S_OFF              = 3'd0;
  localparam logic [2:0] S_RUNNING          = 3'd1;
  localparam logic [2:0] S_LOADING          = 3'd2;
  localparam logic [2:0] S_VERIFICATION_END = 3'd3;
  localparam logic [2:0] S_VERIFYING        = 3'd4;

  localparam logic [7:0] TX_PASS = 8'h53;
  localparam logic [7:0] TX_FAIL = 8'h46;

  localparam logic [ADDR_W-1:0] HDR_BASE = ADDR_W'(HDR_LEN);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [2:0] state;

  // Expected iNES magic byte ("NES\x1A") for header position idx.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h4E;
      2'd1:    b = 8'h45;
      2'd2:    b = 8'h53;
      2'd3:    b = 8'h1A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign nes_state = state;

  // Boot FSM together with all its registered outputs; rst aborts any activity.
  always_ff @(posedge nios_clk) begin
    if (rst) begin
      state         <= S_OFF;
      read_ptr      <= NROM_END;
      rx_clear      <= 1'b1;
      tx_clear      <= 1'b1;
      send_ptr      <= 16'd0;
      tx_DI         <= 8'h00;
      rom_prog      <= 1'b0;
      rom_prog_di   <= 8'h00;
      rom_prog_addr <= '0;
      cpu_run       <= 1'b0;
    end else begin
      rx_clear <= 1'b0;
      tx_clear <= 1'b0;
      case (state)
        S_OFF: begin
          send_ptr <= 16'd0;
          rom_prog <= 1'b0;
          cpu_run  <= 1'b0;
          // read_ptr parks on the last image byte, so read_valid means "image complete"
          if (read_valid) begin
            state    <= S_VERIFYING;
            read_ptr <= '0;
          end else begin
            read_ptr <= NROM_END;
          end
        end
        S_VERIFYING: begin
          if (uart_DO != magic_byte(read_ptr[1:0])) begin
            tx_DI    <= TX_FAIL;
            send_ptr <= 16'd0;
            state    <= S_VERIFICATION_END;
          end else if (read_ptr[1:0] != 2'd3) begin
            read_ptr <= read_ptr + PTR_ONE;
          end else begin
            tx_DI    <= TX_PASS;
            send_ptr <= 16'd0;
            state    <= S_VERIFICATION_END;
          end
        end
        S_VERIFICATION_END: begin
          if (send_done) begin
            send_ptr <= 16'd0;
            tx_clear <= 1'b1;
            if (tx_DI == TX_PASS) begin
              read_ptr      <= HDR_BASE;
              rom_prog_addr <= '0;
              state         <= S_LOADING;
            end else begin
              // failed image: flush the buffer and wait for a fresh one
              rx_clear <= 1'b1;
              read_ptr <= NROM_END;
              state    <= S_OFF;
            end
          end else begin
            send_ptr <= 16'd1;
          end
        end
        S_LOADING: begin
          rom_prog      <= 1'b1;
          rom_prog_di   <= uart_DO;
          rom_prog_addr <= read_ptr - HDR_BASE;
          // the last byte is issued on this edge; read_ptr never passes NROM_END
          if (read_ptr == NROM_END) begin
            state <= S_RUNNING;
          end else begin
            read_ptr <= read_ptr + PTR_ONE;
          end
        end
        S_RUNNING: begin
          cpu_run  <= 1'b1;
          rom_prog <= 1'b0;
        end
        default: begin
          state    <= S_OFF;
          read_ptr <= NROM_END;
          send_ptr <= 16'd0;
          rom_prog <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_boot_controller.sv
// tb_nes_boot_controller
// Scoreboarded bench: each image pushes its expected UART byte, verify-cycle
// count and ROM write stream into queues; a monitor pops and compares them as
// the DUT presents them. Images are randomized around the fixed scenarios.
module tb_nes_boot_controller;

  logic        nios_clk = 1'b0;
  logic        rst;
  logic        read_valid;
  logic [7:0]  uart_DO;
  logic        send_done;
  logic [15:0] read_ptr;
  logic        rx_clear;
  logic        tx_clear;
  logic [15:0] send_ptr;
  logic [7:0]  tx_DI;
  logic        rom_prog;
  logic [7:0]  rom_prog_di;
  logic [15:0] rom_prog_addr;
  logic        cpu_run;
  logic [2:0]  nes_state;

  localparam int IMG_LAST = 24591;  // 0x600F
  localparam int PAYLOAD  = 24576;  // 0x6000

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] img [0:IMG_LAST];
  logic [7:0] magic [0:3];
  wr_t        wq[$];
  logic [7:0] txq[$];
  int         vq[$];

  int vectors     = 0;
  int miscompares = 0;

  nes_boot_controller dut (
    .nios_clk      (nios_clk),
    .rst           (rst),
    .read_valid    (read_valid),
    .uart_DO       (uart_DO),
    .send_done     (send_done),
    .read_ptr      (read_ptr),
    .rx_clear      (rx_clear),
    .tx_clear      (tx_clear),
    .send_ptr      (send_ptr),
    .tx_DI         (tx_DI),
    .rom_prog      (rom_prog),
    .rom_prog_di   (rom_prog_di),
    .rom_prog_addr (rom_prog_addr),
    .cpu_run       (cpu_run),
    .nes_state     (nes_state)
  );

  // receive buffer read is combinational on read_ptr
  assign uart_DO = (int'(read_ptr) <= IMG_LAST) ? img[read_ptr] : 8'h00;

  always #5 nios_clk = ~nios_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush_queues();
    wq.delete();
    txq.delete();
    vq.delete();
  endtask

  // Reference model: derive expected responses from the image contents alone.
  task automatic push_expected();
    int  k;
    wr_t w;
    k = 4;
    for (int i = 3; i >= 0; i--) begin
      if (img[i] != magic[i]) k = i;
    end
    vq.push_back((k < 4) ? k + 1 : 4);
    txq.push_back((k < 4) ? 8'h46 : 8'h53);
    if (k == 4) begin
      for (int i = 0; i < PAYLOAD; i++) begin
        w.addr = 16'(i);
        w.data = img[i + 16];
        wq.push_back(w);
      end
    end
  endtask

  task automatic build_good(input bit rnd);
    for (int i = 0; i < 4; i++) img[i] = magic[i];
    for (int i = 4; i < 16; i++) img[i] = 8'($urandom);
    for (int i = 16; i <= IMG_LAST; i++) img[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic do_reset();
    @(negedge nios_clk);
    rst = 1'b1;
    @(negedge nios_clk);
    check("rst_rx_clear", 32'(rx_clear), 32'd1);
    check("rst_tx_clear", 32'(tx_clear), 32'd1);
    @(negedge nios_clk);
    rst = 1'b0;
    flush_queues();
    check("rst_state", 32'(nes_state), 32'd0);
    check("rst_read_ptr", 32'(read_ptr), 32'h600F);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_send_ptr", 32'(send_ptr), 32'd0);
    check("rst_rom_prog", 32'(rom_prog), 32'd0);
    check("rst_tx_di", 32'(tx_DI), 32'd0);
    check("rst_rom_addr", 32'(rom_prog_addr), 32'd0);
    @(negedge nios_clk);
    check("post_rst_rx_clear", 32'(rx_clear), 32'd0);
    check("post_rst_tx_clear", 32'(tx_clear), 32'd0);
    check("post_rst_read_ptr", 32'(read_ptr), 32'h600F);
  endtask

  // Present a complete image, let it verify, then acknowledge the transmit.
  task automatic feed(input int delay, input bit hold_check);
    int n;
    @(negedge nios_clk);
    read_valid = 1'b1;
    n = 0;
    while (nes_state == 3'd0 && n < 10) begin
      @(negedge nios_clk);
      n++;
    end
    read_valid = 1'b0;
    if (n >= 10) check("start_timeout", 32'd1, 32'd0);
    n = 0;
    while (send_ptr != 16'd1 && n < 20) begin
      @(negedge nios_clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'd1, 32'd0);
    repeat (delay) begin
      @(negedge nios_clk);
      if (hold_check) begin
        check("hold_state", 32'(nes_state), 32'd3);
        check("hold_send_ptr", 32'(send_ptr), 32'd1);
      end
    end
    send_done = 1'b1;
    @(negedge nios_clk);
    send_done = 1'b0;
  endtask

  task automatic check_fail_return();
    check("fail_state", 32'(nes_state), 32'd0);
    check("fail_rx_clear", 32'(rx_clear), 32'd1);
    check("fail_tx_clear", 32'(tx_clear), 32'd1);
    check("fail_send_ptr", 32'(send_ptr), 32'd0);
    check("fail_read_ptr", 32'(read_ptr), 32'h600F);
    @(negedge nios_clk);
    check("fail_rx_clear_end", 32'(rx_clear), 32'd0);
  endtask

  // Monitor: pops scoreboard entries as the DUT produces them.
  initial begin
    logic [15:0] prev_send;
    logic [2:0]  prev_state;
    int          vcnt;
    wr_t         w;
    prev_send  = 16'd0;
    prev_state = 3'd0;
    vcnt       = 0;
    forever begin
      @(negedge nios_clk);
      if (rst) begin
        prev_send  = 16'd0;
        prev_state = 3'd0;
        vcnt       = 0;
      end else begin
        if (rom_prog) begin
          if (wq.size() == 0) begin
            check("rom_unexpected_write", 32'(rom_prog_addr), 32'hFFFF_FFFF);
          end else begin
            w = wq.pop_front();
            check("rom_addr", 32'(rom_prog_addr), 32'(w.addr));
            check("rom_data", 32'(rom_prog_di), 32'(w.data));
          end
        end
        if (nes_state == 3'd4) begin
          check("verify_ptr", 32'(read_ptr), 32'(vcnt));
          vcnt++;
        end
        if (nes_state == 3'd3 && prev_state == 3'd4) begin
          if (vq.size() == 0) check("verify_unexpected", 32'(vcnt), 32'hFFFF_FFFF);
          else check("verify_cycles", 32'(vcnt), 32'(vq.pop_front()));
          vcnt = 0;
        end
        if (send_ptr == 16'd1 && prev_send == 16'd0) begin
          if (txq.size() == 0) check("tx_unexpected", 32'(tx_DI), 32'hFFFF_FFFF);
          else check("tx_byte", 32'(tx_DI), 32'(txq.pop_front()));
        end
        prev_send  = send_ptr;
        prev_state = nes_state;
      end
    end
  end

  // Stimulus: reset, good load, bad magic variants, delayed ack, mid-load reset.
  initial begin
    int n;
    int k;
    logic [7:0] v;
    magic[0] = 8'h4E;
    magic[1] = 8'h45;
    magic[2] = 8'h53;
    magic[3] = 8'h1A;
    rst        = 1'b1;
    read_valid = 1'b0;
    send_done  = 1'b0;
    for (int i = 0; i <= IMG_LAST; i++) img[i] = 8'h00;
    do_reset();

    // good image with index-valued payload, full load
    build_good(1'b0);
    push_expected();
    feed(5, 1'b0);
    check("load_state", 32'(nes_state), 32'd2);
    check("load_tx_clear", 32'(tx_clear), 32'd1);
    check("load_read_ptr", 32'(read_ptr), 32'd16);
    n = 0;
    while (!cpu_run && n < 25000) begin
      @(negedge nios_clk);
      n++;
    end
    check("run_cpu_run", 32'(cpu_run), 32'd1);
    check("run_state", 32'(nes_state), 32'd1);
    check("run_rom_prog", 32'(rom_prog), 32'd0);
    check("run_writes_left", 32'(wq.size()), 32'd0);
    repeat (3) @(negedge nios_clk);
    check("run_hold_state", 32'(nes_state), 32'd1);
    do_reset();

    // bad magic byte 2
    build_good(1'b1);
    img[2] = 8'h58;
    push_expected();
    feed(5, 1'b0);
    check_fail_return();

    // bad first byte
    img[2] = 8'h53;
    img[0] = 8'h00;
    push_expected();
    feed(3, 1'b0);
    check_fail_return();

    // randomized corruption of one magic byte
    for (int r = 0; r < 8; r++) begin
      build_good(1'b1);
      k = int'($urandom_range(0, 3));
      v = 8'($urandom);
      if (v == magic[k]) v = v ^ 8'h01;
      img[k] = v;
      push_expected();
      feed(int'($urandom_range(1, 8)), 1'b0);
      check_fail_return();
    end

    // delayed send_done on a failing image
    img[1] = 8'h00;
    push_expected();
    feed(100, 1'b1);
    check_fail_return();

    // random good image, reset in the middle of loading
    build_good(1'b1);
    push_expected();
    feed(5, 1'b0);
    n = 0;
    while (!(rom_prog && rom_prog_addr == 16'h1234) && n < 6000) begin
      @(negedge nios_clk);
      n++;
    end
    check("abort_reached", 32'(rom_prog_addr), 32'h1234);
    rst = 1'b1;
    @(negedge nios_clk);
    check("abort_state", 32'(nes_state), 32'd0);
    check("abort_rom_prog", 32'(rom_prog), 32'd0);
    check("abort_read_ptr", 32'(read_ptr), 32'h600F);
    check("abort_cpu_run", 32'(cpu_run), 32'd0);
    rst = 1'b0;
    flush_queues();
    repeat (3) @(negedge nios_clk);
    check("abort_idle_state", 32'(nes_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
